// File: rtl/bcd_clock_counter.sv
// ---------------------------------------------------------------------------
// bcd_clock_counter
//
// Two-digit BCD modulo counter for clock-style displays (hours, minutes,
// seconds). Counts up or down in BCD between 00 and MOD-1, supports a
// validated synchronous load, and offers a 12-hour display translation
// when configured as a 24-hour counter.
//
// Parameters: the modulus (2..99) and the reset value, which must be a
// valid BCD value below the modulus.
//
// Ports
//   cp_i      clock, all state updates on the rising edge
//   clr_i     synchronous active-high reset (highest priority)
//   en_i      count enable
//   ld_i      synchronous load strobe (beats en_i)
//   dir_i     count direction: 1 = up, 0 = down
//   d_i       BCD load value, [7:4] tens, [3:0] units
//   mode12_i  1 = 12-hour display format, 0 = 24-hour display format
//   q_o       registered BCD count
//   disp_o    BCD display value, combinational from q_o
//   pm_o      PM flag for 12-hour display
//   co_o      registered one-cycle carry pulse on up-wrap
//   bo_o      registered one-cycle borrow pulse on down-wrap
//   lderr_o   registered one-cycle pulse flagging an illegal load value
// ---------------------------------------------------------------------------
module bcd_clock_counter #(
    parameter int         MOD     = 24,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       cp_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       ld_i,
    input  logic       dir_i,
    input  logic [7:0] d_i,
    input  logic       mode12_i,
    output logic [7:0] q_o,
    output logic [7:0] disp_o,
    output logic       pm_o,
    output logic       co_o,
    output logic       bo_o,
    output logic       lderr_o
);

    localparam int         MAX_BIN = MOD - 1;
    localparam logic [7:0] MAX_BCD = {4'(MAX_BIN / 10), 4'(MAX_BIN % 10)};
    localparam logic [6:0] MOD_BIN = 7'(MOD);
    // The 12-hour translation only makes sense for an hours counter.
    localparam bit         FMT12   = (MOD == 24);

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    logic [7:0] q_q, q_d;
    logic       co_q, co_d;
    logic       bo_q, bo_d;
    logic       lderr_q, lderr_d;

    logic       ld_legal;
    logic [6:0] q_bin;
    logic [6:0] pm_hour;

    // Nibble checks come first so an out-of-range nibble never reaches the
    // binary compare with a meaningful-looking value.
    assign ld_legal = (d_i[7:4] <= 4'd9) && (d_i[3:0] <= 4'd9) &&
                      (bcd_to_bin(d_i) < MOD_BIN);

    // -----------------------------------------------------------------------
    // Next-state logic: LD beats EN; CLR is applied in the register block.
    // -----------------------------------------------------------------------
    always_comb begin
        q_d     = q_q;
        co_d    = 1'b0;
        bo_d    = 1'b0;
        lderr_d = 1'b0;
        if (ld_i) begin
            if (ld_legal) begin
                q_d = d_i;
            end else begin
                q_d     = 8'h00;
                lderr_d = 1'b1;
            end
        end else if (en_i) begin
            if (dir_i) begin
                if (q_q == MAX_BCD) begin
                    q_d  = 8'h00;
                    co_d = 1'b1;
                end else if (q_q[3:0] == 4'd9) begin
                    q_d = {q_q[7:4] + 4'd1, 4'd0};
                end else begin
                    q_d = {q_q[7:4], q_q[3:0] + 4'd1};
                end
            end else begin
                if (q_q == 8'h00) begin
                    q_d  = MAX_BCD;
                    bo_d = 1'b1;
                end else if (q_q[3:0] == 4'd0) begin
                    q_d = {q_q[7:4] - 4'd1, 4'd9};
                end else begin
                    q_d = {q_q[7:4], q_q[3:0] - 4'd1};
                end
            end
        end
    end

    always_ff @(posedge cp_i) begin
        if (clr_i) begin
            q_q     <= RST_VAL;
            co_q    <= 1'b0;
            bo_q    <= 1'b0;
            lderr_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            co_q    <= co_d;
            bo_q    <= bo_d;
            lderr_q <= lderr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Display translation. Hours 13..23 map to 1..11 PM; midnight shows 12 AM.
    // -----------------------------------------------------------------------
    assign q_bin   = bcd_to_bin(q_q);
    assign pm_hour = q_bin - 7'd12;

    always_comb begin
        disp_o = q_q;
        pm_o   = 1'b0;
        if (FMT12 && mode12_i) begin
            if (q_bin == 7'd0) begin
                disp_o = 8'h12;
            end else if (q_bin < 7'd12) begin
                disp_o = q_q;
            end else if (q_bin == 7'd12) begin
                disp_o = 8'h12;
                pm_o   = 1'b1;
            end else begin
                pm_o = 1'b1;
                if (pm_hour >= 7'd10) begin
                    disp_o = {4'd1, 4'(pm_hour - 7'd10)};
                end else begin
                    disp_o = {4'd0, 4'(pm_hour)};
                end
            end
        end
    end

    assign q_o     = q_q;
    assign co_o    = co_q;
    assign bo_o    = bo_q;
    assign lderr_o = lderr_q;

endmodule

// File: tb/tb_bcd_clock_counter.sv
module tb_bcd_clock_counter;

    typedef struct packed {
        logic       clr;
        logic       ld;
        logic       en;
        logic       dir;
        logic [7:0] d;
        logic       m12;
    } stim_t;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] disp;
        logic       pm;
        logic       co;
        logic       bo;
        logic       lderr;
    } obs_t;

    localparam int RST24 = 0;
    localparam int RST60 = 45;

    logic       cp = 1'b0;
    logic       clr = 1'b0, ld = 1'b0, en = 1'b0, dir = 1'b0, mode12 = 1'b0;
    logic [7:0] d = 8'h00;

    logic [7:0] q24, disp24, q60, disp60;
    logic       pm24, co24, bo24, lderr24, pm60, co60, bo60, lderr60;
    obs_t       obs24, obs60;

    int checks = 0;
    int errors = 0;
    int m24 = 0;
    int m60 = 0;
    obs_t sb24[$];
    obs_t sb60[$];

    always #5 cp = ~cp;

    bcd_clock_counter #(.MOD(24), .RST_VAL(8'h00)) dut24 (
        .cp_i(cp), .clr_i(clr), .en_i(en), .ld_i(ld), .dir_i(dir), .d_i(d),
        .mode12_i(mode12), .q_o(q24), .disp_o(disp24), .pm_o(pm24),
        .co_o(co24), .bo_o(bo24), .lderr_o(lderr24)
    );

    bcd_clock_counter #(.MOD(60), .RST_VAL(8'h45)) dut60 (
        .cp_i(cp), .clr_i(clr), .en_i(en), .ld_i(ld), .dir_i(dir), .d_i(d),
        .mode12_i(mode12), .q_o(q60), .disp_o(disp60), .pm_o(pm60),
        .co_o(co60), .bo_o(bo60), .lderr_o(lderr60)
    );

    assign obs24 = {q24, disp24, pm24, co24, bo24, lderr24};
    assign obs60 = {q60, disp60, pm60, co60, bo60, lderr60};

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("q=%h disp=%h pm=%b co=%b bo=%b lderr=%b",
                         o.q, o.disp, o.pm, o.co, o.bo, o.lderr);
    endfunction

    function automatic stim_t mk(input logic c, input logic l, input logic e,
                                 input logic dr, input logic [7:0] dv, input logic m);
        stim_t s;
        s.clr = c; s.ld = l; s.en = e; s.dir = dr; s.d = dv; s.m12 = m;
        return s;
    endfunction

    // Behavioural reference using plain integer arithmetic.
    function automatic obs_t model(input int md, input int rstv, inout int cur, input stim_t s);
        obs_t e;
        int   dv;
        e = '0;
        if (s.clr) begin
            cur = rstv;
        end else if (s.ld) begin
            dv = int'(s.d[7:4]) * 10 + int'(s.d[3:0]);
            if (s.d[7:4] <= 9 && s.d[3:0] <= 9 && dv < md) begin
                cur = dv;
            end else begin
                cur = 0;
                e.lderr = 1'b1;
            end
        end else if (s.en) begin
            if (s.dir) begin
                if (cur == md - 1) begin cur = 0; e.co = 1'b1; end
                else cur = cur + 1;
            end else begin
                if (cur == 0) begin cur = md - 1; e.bo = 1'b1; end
                else cur = cur - 1;
            end
        end
        e.q = to_bcd(cur);
        e.disp = e.q;
        if (md == 24 && s.m12) begin
            if (cur == 0)       begin e.disp = 8'h12; end
            else if (cur < 12)  begin e.disp = to_bcd(cur); end
            else if (cur == 12) begin e.disp = 8'h12; e.pm = 1'b1; end
            else                begin e.disp = to_bcd(cur - 12); e.pm = 1'b1; end
        end
        return e;
    endfunction

    // Drive one cycle, push expectations for both counters, wait past the edge.
    task automatic cyc(input stim_t s);
        @(negedge cp);
        clr = s.clr; ld = s.ld; en = s.en; dir = s.dir; d = s.d; mode12 = s.m12;
        sb24.push_back(model(24, RST24, m24, s));
        sb60.push_back(model(60, RST60, m60, s));
        @(posedge cp);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  e;
        st.push_back(mk(1, 0, 0, 0, 8'h00, 1));
        st.push_back(mk(1, 0, 0, 0, 8'h00, 1));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL reset mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL reset mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_up_wrap();
        stim_t st[$];
        obs_t  e;
        for (int i = 0; i < 25; i++) st.push_back(mk(0, 0, 1, 1, 8'h00, 1));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL up_wrap mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL up_wrap mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_down_wrap();
        stim_t st[$];
        obs_t  e;
        st.push_back(mk(0, 1, 0, 1, 8'h00, 0));
        st.push_back(mk(0, 0, 1, 0, 8'h00, 0));
        st.push_back(mk(0, 0, 1, 0, 8'h00, 0));
        st.push_back(mk(0, 1, 0, 0, 8'h20, 0));
        st.push_back(mk(0, 0, 1, 0, 8'h00, 0));
        st.push_back(mk(0, 0, 1, 0, 8'h00, 0));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL down_wrap mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL down_wrap mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_loads();
        stim_t st[$];
        obs_t  e;
        st.push_back(mk(0, 1, 0, 0, 8'h17, 0));
        st.push_back(mk(0, 1, 0, 0, 8'h25, 0));
        st.push_back(mk(0, 0, 0, 0, 8'h00, 0));
        st.push_back(mk(0, 1, 1, 1, 8'h1A, 0));
        st.push_back(mk(0, 1, 1, 0, 8'h23, 0));
        st.push_back(mk(0, 1, 1, 1, 8'h24, 0));
        st.push_back(mk(0, 1, 0, 0, 8'hA3, 1));
        st.push_back(mk(0, 1, 0, 0, 8'h59, 1));
        st.push_back(mk(0, 1, 1, 1, 8'h00, 1));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL loads mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL loads mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_clr_priority();
        stim_t st[$];
        obs_t  e;
        st.push_back(mk(0, 1, 0, 0, 8'h1F, 0));
        st.push_back(mk(1, 1, 0, 0, 8'h09, 0));
        st.push_back(mk(0, 1, 0, 0, 8'h23, 0));
        st.push_back(mk(1, 0, 1, 1, 8'h00, 0));
        st.push_back(mk(0, 1, 0, 0, 8'h00, 0));
        st.push_back(mk(1, 0, 1, 0, 8'h00, 0));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL clr_priority mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL clr_priority mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_hold();
        stim_t st[$];
        obs_t  e;
        st.push_back(mk(0, 1, 0, 0, 8'h16, 0));
        for (int i = 0; i < 10; i++) st.push_back(mk(0, 0, 0, i[0], 8'h21, 0));
        st.push_back(mk(0, 1, 0, 0, 8'h05, 0));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL hold mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL hold mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_mode12();
        stim_t st[$];
        obs_t  e;
        for (int m = 1; m >= 0; m--)
            for (int v = 0; v < 24; v++)
                st.push_back(mk(0, 1, 0, 0, to_bcd(v), m[0]));
        st.push_back(mk(0, 1, 0, 0, 8'h13, 0));
        st.push_back(mk(0, 0, 0, 0, 8'h00, 1));
        st.push_back(mk(0, 0, 0, 0, 8'h00, 0));
        st.push_back(mk(0, 0, 0, 0, 8'h00, 1));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL mode12 mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL mode12 mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_mod60();
        stim_t st[$];
        obs_t  e;
        st.push_back(mk(0, 1, 0, 0, 8'h58, 1));
        for (int i = 0; i < 4; i++) st.push_back(mk(0, 0, 1, 1, 8'h00, 1));
        st.push_back(mk(0, 1, 0, 0, 8'h00, 1));
        st.push_back(mk(0, 0, 1, 0, 8'h00, 1));
        st.push_back(mk(0, 0, 1, 0, 8'h00, 1));
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL mod60 mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL mod60 mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        obs_t  e;
        logic [7:0] dv;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) dv = to_bcd(int'($urandom_range(0, 65)));
            else dv = 8'($urandom);
            st.push_back(mk($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
                            $urandom_range(0, 3) != 0, 1'($urandom), dv, 1'($urandom)));
        end
        foreach (st[i]) begin
            cyc(st[i]);
            e = sb24.pop_front(); checks++;
            if (obs24 !== e) begin errors++; $display("FAIL back_to_back mod24 #%0d: got %s, expected %s", i, fmt(obs24), fmt(e)); end
            e = sb60.pop_front(); checks++;
            if (obs60 !== e) begin errors++; $display("FAIL back_to_back mod60 #%0d: got %s, expected %s", i, fmt(obs60), fmt(e)); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_loads();
        test_clr_priority();
        test_hold();
        test_mode12();
        test_mod60();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_clock_counter.md
BCD_CLOCK_COUNTER -- requirements
Module: bcd_clock_counter

Interface
REQ-001 Parameter MOD, default 24: counter modulus, legal range 2..99; Q counts 0..MOD-1 in BCD.
REQ-002 Parameter RST_VAL, default 8'h00: BCD value Q takes on reset; SHALL be a valid BCD value below MOD.
REQ-003 CP  input  1  clock; all state updates on the rising edge.
REQ-004 CLR  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  count enable.
REQ-006 LD  input  1  synchronous load strobe.
REQ-007 DIR  input  1  count direction: 1 = up, 0 = down.
REQ-008 D  input  8  BCD load value: [7:4] tens, [3:0] units.
REQ-009 MODE12  input  1  1 = 12-hour display format, 0 = 24-hour display format.
REQ-010 Q  output  8  registered BCD count.
REQ-011 DISP  output  8  BCD display value, derived combinationally from Q.
REQ-012 PM  output  1  PM flag for 12-hour display.
REQ-013 CO  output  1  registered one-cycle carry pulse on up-wrap.
REQ-014 BO  output  1  registered one-cycle borrow pulse on down-wrap.
REQ-015 LDERR  output  1  registered one-cycle pulse flagging an illegal load value.

Function
REQ-016 Per-edge priority: CLR > LD > EN; with none of them active, Q holds its value.
REQ-017 Up count: units 9 -> 0 with tens +1; Q == MOD-1 -> 8'h00.
REQ-018 Down count: units 0 -> 9 with tens -1; Q == 8'h00 -> BCD(MOD-1).
REQ-019 Update latency: Q changes on the same edge that samples EN or LD; no extra pipeline stage.
REQ-020 CO = 1 for exactly the one cycle in which Q has just wrapped from MOD-1 to 00 by an up count; otherwise 0.
REQ-021 BO = 1 for exactly the one cycle in which Q has just wrapped from 00 to MOD-1 by a down count; otherwise 0.
REQ-022 A load never asserts CO or BO, even when the loaded value equals a wrap value.
REQ-023 Legal load: both D nibbles are <= 9 and the BCD value of D is < MOD; Q <= D and LDERR = 0.
REQ-024 Illegal load: Q <= 8'h00 and LDERR = 1 for the following cycle only.
REQ-025 LD is honoured regardless of EN and DIR.
REQ-026 DISP/PM when MOD == 24 and MODE12 == 1:
  - Q = 00 -> DISP = 12, PM = 0
  - Q = 01..11 -> DISP = Q, PM = 0
  - Q = 12 -> DISP = 12, PM = 1
  - Q = 13..23 -> DISP = Q-12 in BCD, PM = 1
REQ-027 DISP/PM in every other case (MODE12 == 0, or MOD != 24): DISP = Q and PM = 0.
REQ-028 MODE12 is purely a display control: changing it never alters Q, CO, BO or LDERR.
REQ-029 Q never holds a non-BCD value or a value >= MOD under any input sequence.

Reset
REQ-030 While CLR = 1 at a rising edge of CP: Q <= RST_VAL; CO, BO and LDERR <= 0.
REQ-031 CLR overrides an in-progress wrap or load on the same edge; no pulse is emitted.
REQ-032 No asynchronous behaviour: before the first CLR edge, outputs are undefined.

Verification
REQ-033 MOD = 24, CLR for 2 cycles, then EN = 1, DIR = 1, MODE12 = 1:
  - Q steps 00..23 then 00
  - CO = 1 only in the cycle Q returns to 00
  - at Q = 13: DISP = 01, PM = 1; at Q = 00: DISP = 12, PM = 0
REQ-034 MOD = 24, load 8'h00, then DIR = 0, EN = 1 -> Q = 23 with BO = 1 for one cycle, then Q = 22 with BO = 0.
REQ-035 Loads: D = 8'h17 -> Q = 17, LDERR = 0; D = 8'h25 -> Q = 00, LDERR = 1; D = 8'h1A -> Q = 00, LDERR = 1.
REQ-036 Simultaneous CLR = 1 and LD = 1 with D = 8'h09 -> Q = RST_VAL, LDERR = 0.
REQ-037 Simultaneous CLR = 1 and an up-wrap condition (Q = 23, EN = 1, DIR = 1) -> Q = RST_VAL, CO = 0.
REQ-038 MOD = 60, MODE12 = 1, up count -> Q goes 59 -> 00 with CO pulse; DISP = Q and PM = 0 throughout.
REQ-039 EN = 0, LD = 0 for 10 cycles -> Q unchanged; EN = 0 with LD = 1 and D = 8'h05 -> Q = 05.
